// File: rtl/carregador_uart_pkg.sv
// Shared types and constants for the UART program loader.
package carregador_uart_pkg;

  localparam int CLKS_POR_BIT_PAD = 434;
  localparam int BYTES_CAB        = 2;
  localparam int BYTES_PALAVRA    = 4;

  typedef enum logic [2:0] {
    ESPERA_TAM_H,
    ESPERA_TAM_L,
    RECEBE_PALAVRA,
    ESCREVE,
    ESPERA_CHECK,
    CONCLUIDO,
    ERRO
  } estado_t;

  typedef enum logic [1:0] {
    RX_OCIOSO,
    RX_INICIO,
    RX_DADOS,
    RX_PARADA
  } rx_estado_t;

endpackage

// File: rtl/carregador_uart_uart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling,
// one-cycle byte_valido / erro_quadro pulses.
module uart_rx
  import carregador_uart_pkg::*;
#(
  parameter int CLKS_POR_BIT = CLKS_POR_BIT_PAD
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_valido_o,
  output logic       erro_quadro_o
);

  localparam int CW = $clog2(CLKS_POR_BIT + 1);
  localparam logic [CW-1:0] MEIO = CW'(CLKS_POR_BIT / 2 - 1);
  localparam logic [CW-1:0] FIM  = CW'(CLKS_POR_BIT - 1);

  rx_estado_t    est_q, est_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [1:0]    sync_q;
  logic          val_q, val_d;
  logic          fe_q, fe_d;
  logic          rx_s;

  assign rx_s          = sync_q[1];
  assign byte_o        = sh_q;
  assign byte_valido_o = val_q;
  assign erro_quadro_o = fe_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      est_q  <= RX_OCIOSO;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      sync_q <= 2'b11;
      val_q  <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      est_q  <= est_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      sync_q <= {sync_q[0], rx};
      val_q  <= val_d;
      fe_q   <= fe_d;
    end
  end

  always_comb begin
    est_d = est_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d  = sh_q;
    val_d = 1'b0;
    fe_d  = 1'b0;
    unique case (est_q)
      RX_OCIOSO: begin
        cnt_d = '0;
        if (!rx_s) est_d = RX_INICIO;
      end
      RX_INICIO: begin
        if (cnt_q == MEIO) begin
          cnt_d = '0;
          bit_d = '0;
          // a start bit already high again is a glitch
          est_d = rx_s ? RX_OCIOSO : RX_DADOS;
        end
      end
      RX_DADOS: begin
        if (cnt_q == FIM) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          if (bit_q == 3'd7) est_d = RX_PARADA;
          else bit_d = bit_q + 1'b1;
        end
      end
      RX_PARADA: begin
        if (cnt_q == FIM) begin
          cnt_d = '0;
          est_d = RX_OCIOSO;
          val_d = rx_s;
          fe_d  = !rx_s;
        end
      end
    endcase
  end

endmodule

// File: rtl/carregador_uart.sv
// UART program loader: length-prefixed big-endian words into
// instruction memory, released after XOR checksum verification.
module carregador_uart
  import carregador_uart_pkg::*;
#(
  parameter int CLKS_POR_BIT = CLKS_POR_BIT_PAD,
  parameter int MAX_PALAVRAS = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx,
  output logic        mem_escrever,
  output logic [31:0] mem_endereco,
  output logic [31:0] mem_dado,
  output logic        proc_parada,
  output logic        carregado,
  output logic        erro
);

  localparam logic [16:0] MAX_N = 17'(MAX_PALAVRAS);
  localparam logic [1:0]  ULT   = 2'(BYTES_PALAVRA - 1);

  estado_t     est_q, est_d;
  logic [7:0]  lenh_q, lenh_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [23:0] pal_q, pal_d;
  logic [1:0]  nb_q, nb_d;
  logic [7:0]  xor_q, xor_d;
  logic [31:0] end_q, end_d;
  logic [31:0] dado_q, dado_d;

  logic [7:0]  rx_byte;
  logic        bv;
  logic        fe;
  logic [15:0] n;

  uart_rx #(.CLKS_POR_BIT(CLKS_POR_BIT)) u_rx (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx            (rx),
    .byte_o        (rx_byte),
    .byte_valido_o (bv),
    .erro_quadro_o (fe)
  );

  assign n            = {lenh_q, rx_byte};
  assign mem_escrever = (est_q == ESCREVE);
  assign mem_endereco = end_q;
  assign mem_dado     = dado_q;
  assign carregado    = (est_q == CONCLUIDO);
  assign erro         = (est_q == ERRO);
  assign proc_parada  = (est_q != CONCLUIDO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      est_q  <= ESPERA_TAM_H;
      lenh_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      pal_q  <= '0;
      nb_q   <= '0;
      xor_q  <= '0;
      end_q  <= '0;
      dado_q <= '0;
    end else begin
      est_q  <= est_d;
      lenh_q <= lenh_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      pal_q  <= pal_d;
      nb_q   <= nb_d;
      xor_q  <= xor_d;
      end_q  <= end_d;
      dado_q <= dado_d;
    end
  end

  always_comb begin
    est_d  = est_q;
    lenh_d = lenh_q;
    len_d  = len_q;
    idx_d  = idx_q;
    pal_d  = pal_q;
    nb_d   = nb_q;
    xor_d  = xor_q;
    end_d  = end_q;
    dado_d = dado_q;
    unique case (est_q)
      ESPERA_TAM_H: begin
        if (bv) begin
          lenh_d = rx_byte;
          xor_d  = xor_q ^ rx_byte;
          est_d  = ESPERA_TAM_L;
        end
      end
      ESPERA_TAM_L: begin
        if (bv) begin
          len_d = n;
          idx_d = '0;
          nb_d  = '0;
          xor_d = xor_q ^ rx_byte;
          if ({1'b0, n} > MAX_N) est_d = ERRO;
          else if (n == 16'd0)   est_d = ESPERA_CHECK;
          else                   est_d = RECEBE_PALAVRA;
        end
      end
      RECEBE_PALAVRA: begin
        if (bv) begin
          nb_d  = nb_q + 1'b1;
          pal_d = {pal_q[15:0], rx_byte};
          xor_d = xor_q ^ rx_byte;
          if (nb_q == ULT) begin
            dado_d = {pal_q, rx_byte};
            end_d  = {14'd0, idx_q, 2'b00};
            est_d  = ESCREVE;
          end
        end
      end
      ESCREVE: begin
        idx_d = idx_q + 16'd1;
        est_d = (idx_q + 16'd1 == len_q) ? ESPERA_CHECK
                                         : RECEBE_PALAVRA;
      end
      ESPERA_CHECK: begin
        if (bv) est_d = (rx_byte == xor_q) ? CONCLUIDO : ERRO;
      end
      CONCLUIDO: ;
      ERRO:      ;
      default:   est_d = ERRO;
    endcase
    if (fe && est_q != CONCLUIDO && est_q != ERRO) est_d = ERRO;
  end

endmodule

// File: tb/tb_carregador_uart.sv
// Scoreboard bench for carregador_uart with a byte-stream
// reference model and randomized images.
module tb_carregador_uart;

  localparam int CPB  = 8;
  localparam int MAXW = 256;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic        mem_escrever;
  logic [31:0] mem_endereco;
  logic [31:0] mem_dado;
  logic        proc_parada;
  logic        carregado;
  logic        erro;

  int  total = 0;
  int  bad = 0;
  wr_t sb[$];
  wr_t w;
  bit  exp_ok;
  bit  exp_err;
  logic ev_prev = 1'b0;
  logic bv_prev = 1'b0;
  logic we_prev = 1'b0;
  logic ok_prev = 1'b0;
  logic er_prev = 1'b0;

  always #5 clock = ~clock;

  carregador_uart #(.CLKS_POR_BIT(CPB), .MAX_PALAVRAS(MAXW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx           (rx),
    .mem_escrever (mem_escrever),
    .mem_endereco (mem_endereco),
    .mem_dado     (mem_dado),
    .proc_parada  (proc_parada),
    .carregado    (carregado),
    .erro         (erro)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  // monitor: pops the scoreboard on every write strobe
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_escrever) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write got addr=%h data=%h required none",
                   mem_endereco, mem_dado);
        end else begin
          w = sb.pop_front();
          chk("wr_addr", mem_endereco, w.a);
          chk("wr_data", mem_dado, w.d);
          chk("wr_latency", {31'd0, bv_prev}, 32'd1);
          chk("wr_width", {31'd0, we_prev}, 32'd0);
        end
      end
      if (carregado && !ok_prev)
        chk("ok_latency", {31'd0, bv_prev}, 32'd1);
      if (erro && !er_prev)
        chk("err_latency", {31'd0, ev_prev}, 32'd1);
    end
    bv_prev <= dut.u_rx.byte_valido_o;
    ev_prev <= dut.u_rx.byte_valido_o | dut.u_rx.erro_quadro_o;
    we_prev <= mem_escrever;
    ok_prev <= carregado;
    er_prev <= erro;
  end

  task automatic chk_reset_outs();
    chk("rst_we", {31'd0, mem_escrever}, 32'd0);
    chk("rst_addr", mem_endereco, 32'd0);
    chk("rst_data", mem_dado, 32'd0);
    chk("rst_stall", {31'd0, proc_parada}, 32'd1);
    chk("rst_loaded", {31'd0, carregado}, 32'd0);
    chk("rst_err", {31'd0, erro}, 32'd0);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    if (check) chk_reset_outs();
    sb.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = !bad_stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    if (bad_stop) repeat (2 * CPB) @(negedge clock);
    repeat ($urandom_range(0, 3)) @(negedge clock);
  endtask

  // reference model: walks the byte stream by protocol position
  task automatic model(input bq_t s, input int bad_idx);
    int n;
    logic [7:0] x;
    wr_t e;
    exp_ok  = 0;
    exp_err = 0;
    n = 0;
    x = 8'h00;
    for (int i = 0; i < s.size(); i++) begin
      if (i == bad_idx) begin
        exp_err = 1;
        return;
      end
      if (i >= 2 && i == 2 + 4 * n) begin
        if (s[i] == x) exp_ok = 1;
        else exp_err = 1;
        return;
      end
      if (i >= 2 && (i - 2) % 4 == 3) begin
        e.a = 32'((i - 2) / 4 * 4);
        e.d = {s[i-3], s[i-2], s[i-1], s[i]};
        sb.push_back(e);
      end
      x ^= s[i];
      if (i == 1) begin
        n = int'({s[0], s[1]});
        if (n > MAXW) begin
          exp_err = 1;
          return;
        end
      end
    end
  endtask

  task automatic run_stream(input string nm, input bq_t s,
                            input int bad_idx);
    model(s, bad_idx);
    foreach (s[i]) send_byte(s[i], i == bad_idx);
    repeat (4 * CPB) @(negedge clock);
    chk({nm, "_loaded"}, {31'd0, carregado}, {31'd0, exp_ok});
    chk({nm, "_err"}, {31'd0, erro}, {31'd0, exp_err});
    chk({nm, "_stall"}, {31'd0, proc_parada}, {31'd0, !exp_ok});
    chk({nm, "_pending"}, 32'(sb.size()), 32'd0);
  endtask

  bq_t t1, t2, t3, t4, t5, tr;

  initial begin
    t1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
    t2 = t1;
    t2[10] = 8'h0D;
    t3 = '{8'h00, 8'h00, 8'h00};
    t4 = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    t5 = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};

    repeat (2) @(negedge clock);
    chk_reset_outs();
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_stream("t1", t1, -1);
    do_reset(0);
    run_stream("t2", t2, -1);
    do_reset(0);
    run_stream("t3", t3, -1);
    do_reset(0);
    run_stream("t4", t4, -1);
    do_reset(0);
    run_stream("t5", t5, 2);

    do_reset(0);
    @(negedge clock);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    chk("glitch_err", {31'd0, erro}, 32'd0);
    run_stream("glitch_t1", t1, -1);

    do_reset(0);
    model(t1, -1);
    for (int i = 0; i < 5; i++) send_byte(t1[i], 0);
    do_reset(1);
    run_stream("replay_t1", t1, -1);

    for (int k = 0; k < 12; k++) begin
      int nw;
      int kind;
      int bidx;
      logic [7:0] x;
      nw = $urandom_range(1, 5);
      kind = $urandom_range(0, 4);
      tr.delete();
      tr.push_back(8'h00);
      tr.push_back(8'(nw));
      for (int j = 0; j < 4 * nw; j++) tr.push_back(8'($urandom));
      x = 8'h00;
      foreach (tr[j]) x ^= tr[j];
      if (kind == 0) x ^= 8'(1 << $urandom_range(0, 7));
      tr.push_back(x);
      bidx = (kind == 1) ? $urandom_range(0, tr.size() - 1) : -1;
      do_reset(0);
      run_stream("rand", tr, bidx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carregador_uart.md
Name: carregador_uart

Overview:
UART program loader that sits directly upstream of the pipelined MIPS core's instruction memory. It receives a framed program image over a serial line, assembles big-endian 32-bit words and writes them sequentially into instruction memory. It holds the core stalled until the image is complete and checksum-verified. It is the only writer of instruction memory; the core's IF stage reads that memory once it is released.

Parameters:
CLKS_POR_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be >= 4.
MAX_PALAVRAS, 256, maximum number of words accepted in one image.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
rx  input  1  UART serial input, idle high, 8N1, LSB first.
mem_escrever  output  1  one-cycle write strobe to instruction memory.
mem_endereco  output  32  byte address of the write, always 4*index.
mem_dado  output  32  word to write.
proc_parada  output  1  1 = hold the core (PC frozen, pipeline flushed).
carregado  output  1  image loaded and verified; sticky until reset.
erro  output  1  load failed; sticky until reset.

Behaviour:
- Reset (async, reset_n=0): mem_escrever=0, mem_endereco=0, mem_dado=0, proc_parada=1, carregado=0, erro=0. The FSM goes to ESPERA_TAM_H, all counters and the checksum clear, and the receiver returns to idle. Reset mid-load discards partial state; a fresh load must then succeed.
- Receiver:
  - rx passes through a 2-flop synchroniser.
  - A falling edge starts a bit timer. At CLKS_POR_BIT/2 the start bit is rechecked; if it is high, the event is a glitch and the receiver returns to idle with no error.
  - 8 data bits are sampled every CLKS_POR_BIT after the start-bit check, LSB first.
  - The stop bit is sampled one CLKS_POR_BIT after the last data bit. High gives a byte_valido pulse of 1 cycle. Low is a framing error.
- Protocol: LEN_H, LEN_L (N, 16-bit big-endian), then N×4 data bytes (each word MSB first), then 1 checksum byte. The checksum is the XOR of every preceding byte including LEN_H/LEN_L.
- FSM states, advancing only on byte_valido unless noted:
  - ESPERA_TAM_H -> ESPERA_TAM_L.
  - ESPERA_TAM_L: if N > MAX_PALAVRAS -> ERRO; if N == 0 -> ESPERA_CHECK; otherwise -> RECEBE_PALAVRA.
  - RECEBE_PALAVRA: shifts bytes into a 32-bit register under a 2-bit byte counter. On the 4th byte -> ESCREVE.
  - ESCREVE (1 cycle, unconditional): mem_escrever=1, mem_endereco=4*index, mem_dado=word. The index then increments. If index == N -> ESPERA_CHECK, else -> RECEBE_PALAVRA.
  - ESPERA_CHECK: if the received byte equals the running XOR -> CONCLUIDO, else -> ERRO.
  - CONCLUIDO: carregado=1, proc_parada=0. Terminal; further rx bytes are ignored.
  - ERRO: erro=1, proc_parada=1. Terminal; further rx bytes are ignored.
- A framing error in any non-terminal state -> ERRO.
- Latency:
  - The write strobe is asserted exactly 1 cycle after the byte_valido of a word's 4th byte.
  - proc_parada falls, and carregado/erro rise, in the cycle after the checksum byte_valido (or the offending byte_valido).
- mem_endereco/mem_dado hold their last value when mem_escrever=0.
- At most one write per 4 bytes. Since CLKS_POR_BIT >= 4, ESCREVE can never collide with the next byte_valido.
- Memory already written before an ERRO is not rolled back; the core stays stalled.

Decomposition:
- Shared package: FSM state encoding (7 states, 3 bits); protocol constants (header length 2, bytes per word 4); default CLKS_POR_BIT.
- One sub-module: uart_rx (synchroniser, bit timer, shift register, byte_valido, erro_quadro), parameterised by CLKS_POR_BIT.
- The loader FSM, word assembly, index counter and XOR accumulator live in carregador_uart.

Test Plan:
1. Send 00 02 20 08 00 05 20 09 00 0A 0C -> writes (addr 0x0, data 0x20080005) then (addr 0x4, data 0x2009000A). Each strobe is 1 cycle, 1 cycle after the 4th byte. After the 0C byte: carregado=1, proc_parada=0, erro=0.
2. Same stream with checksum 0D -> both writes occur; then erro=1, carregado=0, proc_parada stays 1.
3. Send 00 00 00 -> no mem_escrever; carregado=1, proc_parada=0.
4. Send 01 01 (N=257, MAX_PALAVRAS=256) -> erro=1 one cycle after the 2nd byte's byte_valido; no writes; later bytes are ignored.
5. Byte with stop bit driven low, during RECEBE_PALAVRA -> erro=1, no further writes. Separately, a 1-cycle low glitch on idle rx -> no byte_valido, no error.
6. Pull reset_n low after 5 bytes of test 1's stream -> all outputs return to their reset values immediately. Then replay the full test 1 stream -> identical writes, carregado=1.
